// File: rtl/demux_pipe.sv
// Splits one enq stream into an "out" lane and a "forward" lane by a payload routing bit.
// Each lane has its own FIFO, so a stalled lane only blocks input once it is full.
module demux_pipe #(
  parameter int unsigned WIDTH   = 128,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned SEL_BIT = 127
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_enq_ena,
  input  logic [WIDTH-1:0]         in_enq_v,
  output logic                     in_enq_rdy,
  output logic                     out_enq_ena,
  output logic [WIDTH-1:0]         out_enq_v,
  input  logic                     out_enq_rdy,
  output logic                     forward_enq_ena,
  output logic [WIDTH-1:0]         forward_enq_v,
  input  logic                     forward_enq_rdy,
  output logic [$clog2(DEPTH):0]   out_count,
  output logic [$clog2(DEPTH):0]   forward_count
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CW   = PW + 1;
  localparam int unsigned NL   = 2;
  localparam int unsigned LOUT = 0;
  localparam int unsigned LFWD = 1;

  logic [WIDTH-1:0] mem    [NL][DEPTH];
  logic [PW-1:0]    wr_ptr [NL];
  logic [PW-1:0]    rd_ptr [NL];
  logic [CW-1:0]    count  [NL];

  logic [NL-1:0] lane_rdy;
  logic [NL-1:0] show;
  logic [NL-1:0] wr;
  logic [NL-1:0] rd;
  logic          accept;
  logic          sel;

  assign lane_rdy = {forward_enq_rdy, out_enq_rdy};

  // Input ready uses registered occupancy only; a lane that is full this cycle blocks input
  // even if it dequeues, since freed space only shows up in count next cycle.
  always_comb begin
    sel        = in_enq_v[SEL_BIT];
    in_enq_rdy = !rst && (count[LOUT] < CW'(DEPTH)) && (count[LFWD] < CW'(DEPTH));
    accept     = in_enq_ena && in_enq_rdy;
    wr         = '0;
    rd         = '0;
    show       = '0;
    wr[LFWD]   = accept && sel;
    wr[LOUT]   = accept && !sel;
    for (int l = 0; l < NL; l++) begin
      show[l] = !rst && (count[l] != '0);
      rd[l]   = show[l] && lane_rdy[l];
    end
  end

  // Pointers and occupancy per lane
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int l = 0; l < NL; l++) begin
        wr_ptr[l] <= '0;
        rd_ptr[l] <= '0;
        count[l]  <= '0;
      end
    end else begin
      for (int l = 0; l < NL; l++) begin
        if (wr[l]) wr_ptr[l] <= wr_ptr[l] + PW'(1);
        if (rd[l]) rd_ptr[l] <= rd_ptr[l] + PW'(1);
        case ({wr[l], rd[l]})
          2'b10:   count[l] <= count[l] + CW'(1);
          2'b01:   count[l] <= count[l] - CW'(1);
          default: count[l] <= count[l];
        endcase
      end
    end
  end

  // Payload storage needs no reset; occupancy decides what is visible
  always_ff @(posedge clk) begin
    for (int l = 0; l < NL; l++) begin
      if (wr[l]) mem[l][wr_ptr[l]] <= in_enq_v;
    end
  end

  assign out_enq_ena     = rd[LOUT];
  assign forward_enq_ena = rd[LFWD];
  assign out_enq_v       = show[LOUT] ? mem[LOUT][rd_ptr[LOUT]] : '0;
  assign forward_enq_v   = show[LFWD] ? mem[LFWD][rd_ptr[LFWD]] : '0;
  assign out_count       = count[LOUT];
  assign forward_count   = count[LFWD];

endmodule
